// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if
//   Word-addressed req/ack data bus between the MEM-stage access controller
//   (master) and a data-memory slave.
//   bus_req   master->slave  request, held until ack or abort
//   bus_we    master->slave  1 = write
//   bus_addr  master->slave  word address (byte address [31:2])
//   bus_be    master->slave  byte enables
//   bus_wdata master->slave  lane-replicated store data
//   bus_rdata slave->master  read data, valid with bus_ack
//   bus_ack   slave->master  completion
interface mem_access_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [29:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   MEM-stage data-memory access controller. Accepts EX-stage load/store
//   requests, runs one req/ack bus transaction while stalling the pipeline,
//   and returns the aligned, sign/zero-extended load word.
//   Optional feature macro: MEM_ACCESS_MISALIGN_EXC_EN
//     defined   : misaligned H/W accesses are refused and flagged on misalign_exc
//     undefined : misaligned addresses are forced aligned and proceed
// Ports
//   clk, reset (async, active low)
//   ex_en/ex_load/ex_store/ex_funct3/ex_alu_out/ex_store_data : EX request
//   stall           : freeze IF..EX and EX/MEM register
//   mem_data_to_gpr : extended load data, valid with mem_done
//   mem_done        : 1-cycle completion pulse
//   bus_err         : 1-cycle pulse with mem_done on timeout abort
//   misalign_exc    : misaligned access flag (IDLE, combinational)
//   bus             : master side of mem_access_ctrl_if
// Parameters
//   TIMEOUT : BUSY cycles without bus_ack before abort (>= 2)
module mem_access_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ex_en,
  input  logic               ex_load,
  input  logic               ex_store,
  input  logic [2:0]         ex_funct3,
  input  logic [31:0]        ex_alu_out,
  input  logic [31:0]        ex_store_data,
  output logic               stall,
  output logic [31:0]        mem_data_to_gpr,
  output logic               mem_done,
  output logic               bus_err,
  output logic               misalign_exc,
  mem_access_ctrl_if.master  bus
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
  state_e state_q, state_d;

  // request decode
  logic        req, is_h, is_w, accept, timeout;
  logic [31:0] addr_eff;
  logic [3:0]  be_d;
  logic [3:0][7:0] wdata_d;

  // transaction latches
  logic [29:0]     addr_q;
  logic [1:0]      lo_q;
  logic [3:0]      be_q;
  logic            we_q;
  logic [3:0][7:0] wdata_q;
  logic [2:0]      f3_q;
  logic [CW-1:0]   cnt_q;
  logic            err_q;

  // load extraction
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_ext;

  assign req  = ex_en & (ex_load | ex_store);
  // funct3 x1x is a word (covers 010/011/110/111); x01 is a halfword
  assign is_w = ex_funct3[1];
  assign is_h = ~ex_funct3[1] & ex_funct3[0];

`ifdef MEM_ACCESS_MISALIGN_EXC_EN
  logic misal;
  assign misal        = (is_h & ex_alu_out[0]) | (is_w & (ex_alu_out[1:0] != 2'b00));
  assign addr_eff     = ex_alu_out;
  assign misalign_exc = (state_q == S_IDLE) & req & misal;
  assign accept       = (state_q == S_IDLE) & req & ~misal;
`else
  // silently drop the low address bits that the access size cannot use
  assign addr_eff     = {ex_alu_out[31:2], ex_alu_out[1] & ~is_w, ex_alu_out[0] & ~is_h & ~is_w};
  assign misalign_exc = 1'b0;
  assign accept       = (state_q == S_IDLE) & req;
`endif

  always_comb begin
    be_d = 4'b0001 << addr_eff[1:0];
    if (is_w)      be_d = 4'b1111;
    else if (is_h) be_d = addr_eff[1] ? 4'b1100 : 4'b0011;
  end

  // store data replicated across byte lanes so the slave can take any lane
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign wdata_d[i] = is_w ? ex_store_data[8*i +: 8] :
                        is_h ? ex_store_data[8*(i%2) +: 8] :
                               ex_store_data[7:0];
  end

  assign timeout = (cnt_q == CW'(TIMEOUT-1));

  always_comb begin
    ld_b = bus.bus_rdata[{lo_q, 3'b000} +: 8];
    ld_h = lo_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_b[7]}}, ld_b};
      3'b100:  ld_ext = {24'd0, ld_b};
      3'b001:  ld_ext = {{16{ld_h[15]}}, ld_h};
      3'b101:  ld_ext = {16'd0, ld_h};
      default: ld_ext = bus.bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    stall         = 1'b0;
    mem_done      = 1'b0;
    bus_err       = 1'b0;
    bus.bus_req   = 1'b0;
    bus.bus_we    = 1'b0;
    bus.bus_addr  = '0;
    bus.bus_be    = '0;
    bus.bus_wdata = '0;
    case (state_q)
      S_IDLE: begin
        stall = accept;
        if (accept) state_d = S_BUSY;
      end
      S_BUSY: begin
        stall         = 1'b1;
        bus.bus_req   = 1'b1;
        bus.bus_we    = we_q;
        bus.bus_addr  = addr_q;
        bus.bus_be    = be_q;
        bus.bus_wdata = wdata_q;
        if (bus.bus_ack || timeout) state_d = S_DONE;
      end
      S_DONE: begin
        mem_done = 1'b1;
        bus_err  = err_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q          <= '0;
      lo_q            <= '0;
      be_q            <= '0;
      we_q            <= 1'b0;
      wdata_q         <= '0;
      f3_q            <= '0;
      cnt_q           <= '0;
      err_q           <= 1'b0;
      mem_data_to_gpr <= '0;
    end else begin
      if (accept) begin
        addr_q  <= addr_eff[31:2];
        lo_q    <= addr_eff[1:0];
        be_q    <= be_d;
        we_q    <= ex_store & ~ex_load;  // load+store together is a load
        wdata_q <= wdata_d;
        f3_q    <= ex_funct3;
      end
      case (state_q)
        S_BUSY: begin
          cnt_q <= cnt_q + CW'(1);
          // ack on the last allowed cycle still completes normally
          if (bus.bus_ack) begin
            mem_data_to_gpr <= we_q ? 32'd0 : ld_ext;
            err_q           <= 1'b0;
          end else if (timeout) begin
            mem_data_to_gpr <= 32'd0;
            err_q           <= 1'b1;
          end
        end
        S_DONE: cnt_q <= '0;
        default: begin
          cnt_q <= '0;
          err_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_en, ex_load, ex_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_alu_out, ex_store_data;
  logic        stall, mem_done, bus_err, misalign_exc;
  logic [31:0] mem_data_to_gpr;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_data = 32'd0;

  mem_access_ctrl_if bif();

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk             (clk),
    .reset           (rst_n),
    .ex_en           (ex_en),
    .ex_load         (ex_load),
    .ex_store        (ex_store),
    .ex_funct3       (ex_funct3),
    .ex_alu_out      (ex_alu_out),
    .ex_store_data   (ex_store_data),
    .stall           (stall),
    .mem_data_to_gpr (mem_data_to_gpr),
    .mem_done        (mem_done),
    .bus_err         (bus_err),
    .misalign_exc    (misalign_exc),
    .bus             (bif.master)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: access size from funct3, natural alignment by arithmetic,
  // lane replication by modulo, extraction by shift-and-mask.
  function automatic void model(input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] sd, input logic [31:0] rd,
                                output int sz, output logic [31:0] aa,
                                output logic [3:0] be, output logic [31:0] wd,
                                output logic [31:0] lv);
    int off;
    logic sgn;
    logic [63:0] v, mask;
    case (f3)
      3'b000, 3'b100: sz = 1;
      3'b001, 3'b101: sz = 2;
      default:        sz = 4;
    endcase
    sgn = (f3 == 3'b000) || (f3 == 3'b001);
    aa  = a - (a % sz);
    off = int'(aa % 4);
    be  = 4'(((1 << sz) - 1) << off);
    for (int i = 0; i < 4; i++) wd[8*i +: 8] = sd[8*(i % sz) +: 8];
    if (sz == 4) lv = rd;
    else begin
      v    = {32'd0, rd} >> (8*off);
      mask = (64'd1 << (8*sz)) - 64'd1;
      v    = v & mask;
      if (sgn && v[8*sz-1]) v = v | ~mask;
      lv = v[31:0];
    end
  endfunction

  // Starts at a negedge with the controller idle; returns at a negedge, idle.
  // k = BUSY cycles before the acking cycle (k >= TO means no ack).
  task automatic do_access(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd,
                           input logic [31:0] rd, input int k);
    int sz;
    logic [31:0] aa, wd, lv, exp;
    logic [3:0] be;
    logic mis, is_st, acked;
    model(f3, a, sd, rd, sz, aa, be, wd, lv);
    mis   = ((sz == 2) && (a % 2 != 0)) || ((sz == 4) && (a % 4 != 0));
    is_st = st & ~ld;
    ex_en = 1'b1; ex_load = ld; ex_store = st; ex_funct3 = f3;
    ex_alu_out = a; ex_store_data = sd;
    #1;
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
    if (mis) begin
      chk("misal_exc", misalign_exc, 1'b1);
      chk("misal_stall", stall, 1'b0);
      chk("misal_done", mem_done, 1'b0);
      @(negedge clk);
      ex_en = 1'b0;
      #1;
      chk("misal_noreq", bif.bus_req, 1'b0);
      chk("misal_idle_stall", stall, 1'b0);
      chk("misal_data_hold", mem_data_to_gpr, last_data);
      return;
    end
`endif
    chk("misal_exc_off", misalign_exc, 1'b0);
    chk("accept_stall", stall, 1'b1);
    chk("accept_noreq", bif.bus_req, 1'b0);
    @(negedge clk);
    // garbage on EX inputs while busy must be ignored
    ex_en = 1'($urandom); ex_load = 1'($urandom); ex_store = 1'($urandom);
    ex_funct3 = 3'($urandom); ex_alu_out = $urandom; ex_store_data = $urandom;
    acked = 1'b0;
    for (int i = 0; i < TO; i++) begin
      chk("busy_req", bif.bus_req, 1'b1);
      chk("busy_stall", stall, 1'b1);
      chk("busy_addr", bif.bus_addr, aa[31:2]);
      chk("busy_be", bif.bus_be, be);
      chk("busy_we", bif.bus_we, is_st);
      if (is_st) chk("busy_wdata", bif.bus_wdata, wd);
      chk("busy_nodone", mem_done, 1'b0);
      if (i == k) begin bif.bus_ack = 1'b1; bif.bus_rdata = rd; end
      @(negedge clk);
      bif.bus_ack = 1'b0; bif.bus_rdata = $urandom;
      if (i == k) begin acked = 1'b1; break; end
    end
    ex_en = 1'b0;
    exp = (acked && !is_st) ? lv : 32'd0;
    chk("done_pulse", mem_done, 1'b1);
    chk("done_stall", stall, 1'b0);
    chk("done_noreq", bif.bus_req, 1'b0);
    chk("done_err", bus_err, !acked);
    chk("done_data", mem_data_to_gpr, exp);
    last_data = exp;
    @(negedge clk);
    chk("idle_nodone", mem_done, 1'b0);
    chk("idle_noerr", bus_err, 1'b0);
    chk("idle_noreq", bif.bus_req, 1'b0);
    chk("idle_hold", mem_data_to_gpr, last_data);
  endtask

  initial begin
    rst_n = 1'b0;
    ex_en = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_funct3 = 3'd0;
    ex_alu_out = 32'd0; ex_store_data = 32'd0;
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_stall", stall, 1'b0);
    chk("rst_req", bif.bus_req, 1'b0);
    chk("rst_done", mem_done, 1'b0);
    chk("rst_err", bus_err, 1'b0);
    chk("rst_data", mem_data_to_gpr, 32'd0);
    chk("rst_addr", bif.bus_addr, 30'd0);
    bif.bus_ack = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // directed
    do_access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2);
    do_access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 1);
    do_access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 0);
    do_access(1, 0, 3'b101, 32'h102, 32'h0, 32'h80FFFFFF, 3);
    do_access(0, 1, 3'b000, 32'h201, 32'h12345678, 32'h55AA55AA, 1);
    do_access(0, 1, 3'b001, 32'h202, 32'hCAFE1234, 32'h0, 0);
    do_access(1, 0, 3'b010, 32'h300, 32'h0, 32'h11111111, TO + 5);
    do_access(1, 0, 3'b010, 32'h300, 32'h0, 32'h22222222, TO - 1);
    do_access(1, 0, 3'b010, 32'h102, 32'h0, 32'hCAFEBABE, 1);
    do_access(1, 1, 3'b001, 32'h206, 32'hFFFFFFFF, 32'h8001_7FFF, 0);

    // no accept: enable without load/store, and load without enable
    ex_en = 1'b1; ex_load = 1'b0; ex_store = 1'b0; ex_alu_out = 32'h40;
    #1 chk("noop_stall", stall, 1'b0);
    @(negedge clk);
    chk("noop_noreq", bif.bus_req, 1'b0);
    ex_en = 1'b0; ex_load = 1'b1;
    #1 chk("noen_stall", stall, 1'b0);
    @(negedge clk);
    chk("noen_noreq", bif.bus_req, 1'b0);
    ex_load = 1'b0;

    // reset during BUSY, then a stray ack
    ex_en = 1'b1; ex_load = 1'b1; ex_funct3 = 3'b010; ex_alu_out = 32'h400;
    @(negedge clk);
    ex_en = 1'b0; ex_load = 1'b0;
    #1 chk("rbusy_req", bif.bus_req, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rbusy_req_drop", bif.bus_req, 1'b0);
    chk("rbusy_stall_drop", stall, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; bif.bus_ack = 1'b1; bif.bus_rdata = 32'h12345678;
    @(negedge clk);
    chk("stray_noreq", bif.bus_req, 1'b0);
    chk("stray_nodone", mem_done, 1'b0);
    chk("stray_stall", stall, 1'b0);
    @(negedge clk);
    bif.bus_ack = 1'b0;
    chk("stray_nodone2", mem_done, 1'b0);
    chk("stray_data", mem_data_to_gpr, 32'd0);
    last_data = 32'd0;

    // randomized
    for (int n = 0; n < 40; n++) begin
      int r, k;
      logic ld, st;
      r  = $urandom_range(0, 2);
      ld = (r != 1);
      st = (r != 0);
      k  = ($urandom_range(0, 9) == 0) ? TO + 5 : $urandom_range(0, 4);
      do_access(ld, st, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, k);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
